height_sqrt_unit: RTL and testbench

- Sequential fixed-point square-root engine directly downstream of the sensor-averaging stage.
- Takes the 8-bit averaged height, computes floor(sqrt(height)) in unsigned Q4.FRAC_BITS format plus the integer remainder, and presents them on a valid/ready output.
- Uses a digit-by-digit restoring algorithm, 2 radicand bits per cycle, with one iterative datapath and no multipliers.

---
 rtl/height_sqrt_unit.sv | 110 +++++++++++
 tb/tb_height_sqrt_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/height_sqrt_unit.sv
// Iterative fixed-point square root of the averaged sensor height.
// Restoring digit-by-digit method, two radicand bits retired per clock.
module height_sqrt_unit #(
  parameter  int FRAC_BITS = 8,
  localparam int ROOT_W    = 4 + FRAC_BITS,
  localparam int ITER      = 4 + FRAC_BITS,
  localparam int RAD_W     = 8 + 2 * FRAC_BITS,
  localparam int REM_W     = ROOT_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        height,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] root,
  output logic [REM_W-1:0]  rem,
  output logic              busy
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  logic [RAD_W-1:0]   rad;
  logic [ROOT_W-1:0]  proot;
  logic [REM_W-1:0]   prem;
  logic [CNT_W-1:0]   cnt;

  logic [REM_W:0]     cur;
  logic [REM_W:0]     sub;
  logic [REM_W:0]     diff;
  logic               neg;
  logic [ROOT_W-1:0]  proot_next;
  logic [REM_W-1:0]   prem_next;
  logic               unused_msbs;

  // Between steps the partial remainder stays below 2^(REM_W-1), so its top
  // bit never reaches the trial subtraction; only the final result uses it.
  always_comb begin
    cur        = {prem[REM_W-2:0], rad[RAD_W-1 -: 2]};
    sub        = {proot, 2'b01};
    neg        = cur < sub;
    diff       = cur - sub;
    prem_next  = neg ? cur[REM_W-1:0] : diff[REM_W-1:0];
    proot_next = {proot[ROOT_W-2:0], ~neg};
  end

  assign unused_msbs = prem[REM_W-1] ^ diff[REM_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rad       <= '0;
      proot     <= '0;
      prem      <= '0;
      cnt       <= '0;
      root      <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            rad      <= {height, {(2 * FRAC_BITS){1'b0}}};
            proot    <= '0;
            prem     <= '0;
            cnt      <= CNT_W'(ITER - 1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          rad   <= {rad[RAD_W-3:0], 2'b00};
          proot <= proot_next;
          prem  <= prem_next;
          if (cnt == '0) begin
            root      <= proot_next;
            rem       <= prem_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Re-opening the input only after the result is taken keeps the
          // held result stable and rules out a same-cycle accept.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_height_sqrt_unit.sv
// Scoreboard bench for height_sqrt_unit: a reference integer square root
// predicts every result, and a monitor checks each output handshake.
module tb_height_sqrt_unit;

  localparam int FRAC_BITS = 8;
  localparam int ROOT_W    = 4 + FRAC_BITS;
  localparam int REM_W     = ROOT_W + 1;
  localparam int ITER      = 4 + FRAC_BITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        height;
  logic              out_valid;
  logic              out_ready;
  logic [ROOT_W-1:0] root;
  logic [REM_W-1:0]  rem;
  logic              busy;

  typedef struct {
    int h;
    int r;
    int m;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   randReady  = 1'b0;
  bit   readyForce = 1'b1;

  height_sqrt_unit #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .height   (height),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .root     (root),
    .rem      (rem),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = randReady ? ($urandom_range(0, 3) != 0) : readyForce;
  end

  // Largest r with r*r <= h * 2^(2*FRAC_BITS), found by binary search.
  function automatic void refSqrt(input int h, output int r, output int m);
    longint v;
    int lo;
    int hi;
    int mid;
    v  = longint'(h) << (2 * FRAC_BITS);
    lo = 0;
    hi = (1 << ROOT_W) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (longint'(mid) * longint'(mid) <= v) lo = mid;
      else hi = mid - 1;
    end
    r = lo;
    m = int'(v - longint'(lo) * longint'(lo));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpected_output: got root=%0d rem=%0d, required no output", root, rem);
      return;
    end
    e = sb.pop_front();
    check($sformatf("root(h=%0d)", e.h), 64'(root), 64'(e.r));
    check($sformatf("rem(h=%0d)", e.h), 64'(rem), 64'(e.m));
    check($sformatf("identity(h=%0d)", e.h),
          64'(longint'(root) * longint'(root) + longint'(rem)),
          64'(longint'(e.h) << (2 * FRAC_BITS)));
    check($sformatf("rem_bound(h=%0d)", e.h), 64'(int'(rem) <= 2 * int'(root)), 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) checkOutput();
  end

  task automatic applyStimulus(input int h);
    int r;
    int m;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      waitCycle();
      n++;
    end
    if (in_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL in_ready_timeout(h=%0d): got in_ready=%b, required 1", h, in_ready);
      return;
    end
    refSqrt(h, r, m);
    sb.push_back('{h, r, m});
    in_valid = 1'b1;
    height   = 8'(h);
    waitCycle();
    in_valid = 1'b0;
    height   = 8'($urandom);
  endtask

  task automatic runDirected(input int h);
    int cycles;
    int busyCnt;
    applyStimulus(h);
    cycles  = 0;
    busyCnt = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busyCnt++;
      waitCycle();
      cycles++;
    end
    check($sformatf("latency(h=%0d)", h), 64'(cycles), 64'(ITER));
    check($sformatf("busy_cycles(h=%0d)", h), 64'(busyCnt), 64'(ITER));
    waitCycle();
    waitCycle();
  endtask

  initial begin
    int perm[256];
    int r;
    int m;
    int n;
    int j;
    int tmp;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    height   = 8'd0;
    repeat (3) waitCycle();
    check("reset_root", 64'(root), 64'd0);
    check("reset_rem", 64'(rem), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    waitCycle();

    runDirected(100);
    runDirected(255);
    runDirected(2);
    runDirected(0);

    // Hold the result in DONE while pushing other heights at the input.
    readyForce = 1'b0;
    applyStimulus(77);
    refSqrt(77, r, m);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      waitCycle();
      n++;
    end
    check("stall_reach_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      height   = 8'($urandom);
      waitCycle();
      check("stall_root", 64'(root), 64'(r));
      check("stall_rem", 64'(rem), 64'(m));
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid   = 1'b0;
    readyForce = 1'b1;
    waitCycle();
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    waitCycle();
    check("release_no_capture", 64'(busy), 64'd0);
    check("release_sb_empty", 64'(sb.size()), 64'd0);

    // Abort mid-calculation; the pending result must never appear.
    applyStimulus(200);
    repeat (5) waitCycle();
    rst_n = 1'b0;
    #1;
    check("abort_root", 64'(root), 64'd0);
    check("abort_rem", 64'(rem), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    sb.delete();
    #2;
    rst_n = 1'b1;
    waitCycle();
    runDirected(49);

    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j       = int'($urandom_range(0, i));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    randReady = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) waitCycle();
      applyStimulus(perm[i]);
    end
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      waitCycle();
      n++;
    end
    randReady = 1'b0;
    check("sweep_drained", 64'(sb.size()), 64'd0);
    repeat (3) waitCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got time limit reached, required completion");
    $fatal(1);
  end

endmodule
